// File: rtl/mm_result_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_result_drain_pkg
// Description : Shared types and defaults for the matrix-engine result drain.
//               FIFO entry layout is {i, j, data}, data in the low bits.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_result_drain_pkg;

    localparam int IW_DEFAULT = 20;
    localparam int DW_DEFAULT = 40;

    // Serializer states; the encoding is fixed so it can be probed externally
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10
    } drain_state_t;

    // Width of one stored entry {i, j, data}
    function automatic int entry_width(input int iw, input int dw);
        return 2 * iw + dw;
    endfunction

endpackage : mm_result_drain_pkg
`default_nettype wire

// File: rtl/mm_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mm_result_fifo
// Description : Synchronous FIFO with wraparound pointers, occupancy count and
//               full/empty flags. Pushes when full and pops when empty are
//               ignored so the pointers can never cross.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule : mm_result_fifo
`default_nettype wire

// File: rtl/mm_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : mm_result_drain
// Description : Captures matrix-engine results into a FIFO and serializes each
//               DW-bit result as two DW/2-bit beats (low half first) on a
//               valid/ready bus. Tracks engine finish and flags drained/done.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_result_drain
    import mm_result_drain_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = IW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_i,
    input  logic [IW-1:0]            wr_j,
    input  logic [DW-1:0]            wr_data,
    input  logic                     mm_finish,
    output logic                     full,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IW-1:0]            out_i,
    output logic [IW-1:0]            out_j,
    output logic                     out_hi,
    output logic [DW/2-1:0]          out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic                     done
);

    localparam int EW = entry_width(IW, DW);
    localparam int HW = DW / 2;

    drain_state_t   r_state;
    drain_state_t   w_next_state;
    logic [EW-1:0]  w_head;
    logic           w_empty;
    logic           w_push;
    logic           w_drop;
    logic           w_pop;
    logic           w_load_lo;
    logic           w_load_hi;
    logic [HW-1:0]  r_hi_half;
    logic           r_finish_seen;
    logic           r_err;
    logic           r_done;

    // Results arriving when full (decoded from registered count) or after finish are lost
    assign w_push = wr_en && !full && !r_finish_seen;
    assign w_drop = wr_en && (full || r_finish_seen);

    mm_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata ({wr_i, wr_j, wr_data}),
        .pop   (w_pop),
        .rdata (w_head),
        .count (count),
        .full  (full),
        .empty (w_empty)
    );

    // Valid comes only from the registered state, never from out_ready
    assign out_valid = (r_state != ST_IDLE);
    assign err       = r_err;
    assign done      = r_done;

    // Serializer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and pop/load decode; HI chains straight into the next LO
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load_lo    = 1'b0;
        w_load_hi    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_load_lo    = 1'b1;
                    w_next_state = ST_LO;
                end
            end
            ST_LO: begin
                if (out_ready) begin
                    w_load_hi    = 1'b1;
                    w_next_state = ST_HI;
                end
            end
            ST_HI: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_load_lo    = 1'b1;
                        w_next_state = ST_LO;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output register; holds while stalled because loads only occur on handshake or from IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_i     <= '0;
            out_j     <= '0;
            out_hi    <= 1'b0;
            out_data  <= '0;
            r_hi_half <= '0;
        end else if (w_load_lo) begin
            out_i     <= w_head[DW+2*IW-1:DW+IW];
            out_j     <= w_head[DW+IW-1:DW];
            out_hi    <= 1'b0;
            out_data  <= w_head[HW-1:0];
            r_hi_half <= w_head[DW-1:HW];
        end else if (w_load_hi) begin
            out_hi    <= 1'b1;
            out_data  <= r_hi_half;
        end
    end

    // Sticky status flags: finish seen, dropped result, finished-and-drained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_finish_seen <= 1'b0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (mm_finish) r_finish_seen <= 1'b1;
            if (w_drop)    r_err         <= 1'b1;
            if (r_finish_seen && w_empty && (r_state == ST_IDLE)) r_done <= 1'b1;
        end
    end

endmodule : mm_result_drain
`default_nettype wire

// File: tb/tb_mm_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_result_drain
// Description : Self-checking bench for mm_result_drain: table-driven single
//               results plus hand-written multi-cycle sequences, with a beat
//               scoreboard checked on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_result_drain;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [19:0] wr_i = '0;
    logic [19:0] wr_j = '0;
    logic [39:0] wr_data = '0;
    logic        mm_finish = 1'b0;
    logic        full;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_i;
    logic [19:0] out_j;
    logic        out_hi;
    logic [19:0] out_data;
    logic [2:0]  count;
    logic        err;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] i;
        logic [19:0] j;
        logic        hi;
        logic [19:0] data;
    } beat_t;

    typedef struct {
        logic [19:0] i;
        logic [19:0] j;
        logic [39:0] data;
        logic [19:0] exp_lo;
        logic [19:0] exp_hi;
    } vec_t;

    beat_t sb[$];

    mm_result_drain #(
        .DEPTH (DEPTH),
        .IW    (20),
        .DW    (40)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_i      (wr_i),
        .wr_j      (wr_j),
        .wr_data   (wr_data),
        .mm_finish (mm_finish),
        .full      (full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_j     (out_j),
        .out_hi    (out_hi),
        .out_data  (out_data),
        .count     (count),
        .err       (err),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one write for the next edge; optionally record its two expected beats
    task automatic push_one(input logic [19:0] i, input logic [19:0] j, input logic [39:0] d,
                            input logic [19:0] lo, input logic [19:0] hi, input bit expect_out);
        beat_t b;
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_i    = i;
        wr_j    = j;
        wr_data = d;
        if (expect_out) begin
            b.i = i; b.j = j; b.hi = 1'b0; b.data = lo;
            sb.push_back(b);
            b.hi = 1'b1; b.data = hi;
            sb.push_back(b);
        end
    endtask

    task automatic idle_inputs();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (sb.size() != 0 && n < 100);
        check(name, 64'(sb.size()), 64'd0);
        @(negedge clk);
        check({name, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        wr_en     = 1'b0;
        mm_finish = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sb.delete();
        reset = 1'b0;
    endtask

    // Output monitor: scoreboard compare on handshake, stability check while stalled
    logic        prev_stall = 1'b0;
    logic [61:0] prev_bits  = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold_stable", 64'({out_valid, out_i, out_j, out_hi, out_data}), 64'(prev_bits));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got i=%0h j=%0h hi=%0b data=%0h expected none",
                             out_i, out_j, out_hi, out_data);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat", 64'({out_i, out_j, out_hi, out_data}), 64'({e.i, e.j, e.hi, e.data}));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_bits  = {1'b1, out_i, out_j, out_hi, out_data};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[4];
        logic [39:0] d;
        int n;

        vt[0] = '{i: 20'd1,     j: 20'd2,     data: 40'h12345_6789A, exp_lo: 20'h6789A, exp_hi: 20'h12345};
        vt[1] = '{i: 20'hFFFFF, j: 20'h00000, data: 40'hFFFFF_00000, exp_lo: 20'h00000, exp_hi: 20'hFFFFF};
        vt[2] = '{i: 20'h00007, j: 20'hABCDE, data: 40'h00001_80000, exp_lo: 20'h80000, exp_hi: 20'h00001};
        vt[3] = '{i: 20'h55555, j: 20'hAAAAA, data: 40'hA5A5A_5A5A5, exp_lo: 20'h5A5A5, exp_hi: 20'hA5A5A};

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_fields", 64'({out_i, out_j, out_hi, out_data}), 64'd0);
        check("rst_flags", 64'({full, err, done}), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        do_reset();

        // Table-driven single results with latency check
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_one(vt[k].i, vt[k].j, vt[k].data, vt[k].exp_lo, vt[k].exp_hi, 1'b1);
            idle_inputs();
            @(negedge clk);
            check("lat_not_yet", 64'({out_valid, count}), 64'({1'b0, 3'd1}));
            @(negedge clk);
            check("lat_first_beat", 64'({out_valid, out_hi, count}), 64'({1'b1, 1'b0, 3'd0}));
            wait_drain("table_drain");
        end

        // Finish pulse after idle: done follows one edge after finish is recorded
        @(posedge clk); #1; mm_finish = 1'b1;
        @(posedge clk); #1; mm_finish = 1'b0;
        @(negedge clk);
        check("done_pre", 64'(done), 64'd0);
        @(negedge clk);
        check("done_set", 64'(done), 64'd1);
        do_reset();

        // Backpressure: low beat held five cycles
        out_ready = 1'b0;
        push_one(20'd1, 20'd2, 40'h12345_6789A, 20'h6789A, 20'h12345, 1'b1);
        idle_inputs();
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold", 64'({out_valid, out_hi, out_data, count}), 64'({1'b1, 1'b0, 20'h6789A, 3'd0}));
        end
        @(posedge clk); #1; out_ready = 1'b1;
        wait_drain("bp_drain");
        do_reset();

        // Overflow: one in output register, four in FIFO, sixth dropped
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d = 40'h100 + 40'(k);
            push_one(20'(k), 20'(k + 10), d, d[19:0], d[39:20], 1'b1);
        end
        idle_inputs();
        @(negedge clk);
        check("ovf_full", 64'({full, count, err}), 64'({1'b1, 3'd4, 1'b0}));
        push_one(20'hDEAD0, 20'hDEAD1, 40'hDEADB_EEF00, 20'h0, 20'h0, 1'b0);
        idle_inputs();
        @(negedge clk);
        check("ovf_err", 64'({err, count}), 64'({1'b1, 3'd4}));
        @(posedge clk); #1; out_ready = 1'b1;
        wait_drain("ovf_drain");
        do_reset();

        // Wraparound and back-to-back: 20 beats with no bubble
        out_ready = 1'b1;
        fork
            begin
                int k = 0;
                logic [39:0] dk;
                while (k < 10) begin
                    @(posedge clk);
                    #1;
                    if (!full) begin
                        dk = 40'(k);
                        push_one_now(20'(k), 20'(k + 1), dk);
                        k++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(posedge clk); #1; wr_en = 1'b0;
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("b2b_start", 64'(out_valid), 64'd1);
                for (int b = 1; b < 20; b++) begin
                    @(negedge clk);
                    check("b2b_valid", 64'(out_valid), 64'd1);
                end
                @(negedge clk);
                check("b2b_end_idle", 64'(out_valid), 64'd0);
                #1;
                check("b2b_sb_empty", 64'(sb.size()), 64'd0);
            end
        join
        do_reset();

        // Finish ordering: finish with results queued, done only after last HI
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = 40'hF0000_00000 + 40'(k);
            push_one(20'(k + 20), 20'(k + 30), d, d[19:0], d[39:20], 1'b1);
        end
        idle_inputs();
        mm_finish = 1'b1;
        out_ready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (!out_valid || n > 50) break;
            check("fin_done_low", 64'(done), 64'd0);
        end
        check("fin_done_at_idle", 64'({out_valid, done, count}), 64'({1'b0, 1'b0, 3'd0}));
        @(negedge clk);
        check("fin_done_set", 64'(done), 64'd1);
        mm_finish = 1'b0;
        push_one(20'h1, 20'h1, 40'h77777_77777, 20'h0, 20'h0, 1'b0);
        idle_inputs();
        @(negedge clk);
        check("fin_late_write", 64'({err, done, count}), 64'({1'b1, 1'b1, 3'd0}));
        repeat (3) @(negedge clk);
        check("fin_no_output", 64'(out_valid), 64'd0);
        do_reset();

        // Reset during an HI beat with two entries queued
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = 40'h0ABC0_00000 + 40'(k);
            push_one(20'(k + 40), 20'(k + 50), d, d[19:0], d[39:20], 1'b1);
        end
        idle_inputs();
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(posedge clk); #1; mm_finish = 1'b1;
        @(posedge clk); #1; mm_finish = 1'b0;
        wr_en = 1'b1; wr_data = 40'h99999_99999;
        @(posedge clk); #1; wr_en = 1'b0;
        @(negedge clk);
        check("mid_before_rst", 64'({out_valid, out_hi, count, err, done}),
              64'({1'b1, 1'b1, 3'd2, 1'b1, 1'b0}));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out", 64'({out_valid, out_hi, out_data}), 64'd0);
        check("mid_rst_state", 64'({count, err, done, full}), 64'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        push_one(20'h3, 20'h4, 40'h13579_2468A, 20'h2468A, 20'h13579, 1'b1);
        idle_inputs();
        wait_drain("post_rst_drain");
        check("post_rst_flags", 64'({err, done}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Same-cycle write drive used where the caller already sits just after an edge
    task automatic push_one_now(input logic [19:0] i, input logic [19:0] j, input logic [39:0] d);
        beat_t b;
        wr_en   = 1'b1;
        wr_i    = i;
        wr_j    = j;
        wr_data = d;
        b.i = i; b.j = j; b.hi = 1'b0; b.data = d[19:0];
        sb.push_back(b);
        b.hi = 1'b1; b.data = d[39:20];
        sb.push_back(b);
    endtask

endmodule : tb_mm_result_drain
`default_nettype wire

// File: doc/mm_result_drain.md
Name: mm_result_drain

Overview:
- Downstream stage of the matrix engine. Captures each result the engine writes (write pulse, i/j indices, 40-bit write_data) into a small FIFO.
- Serializes every 40-bit result into two 20-bit beats on a valid/ready bus. This matches the engine's 20-bit data path and the result memory port.
- Tracks the engine's finish and raises done once every captured result has drained.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- IW, 20, width of the i and j indices.
- DW, 40, result width; must be even; beat width is DW/2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  engine write strobe; one result per high cycle
- wr_i  in  IW  row index of the result
- wr_j  in  IW  column index of the result
- wr_data  in  DW  result value
- mm_finish  in  1  engine finished; level or pulse
- full  out  1  FIFO full, advisory to the engine
- out_valid  out  1  beat valid
- out_ready  in  1  sink accepts the beat
- out_i  out  IW  row index of the current beat
- out_j  out  IW  column index of the current beat
- out_hi  out  1  0 = low half, 1 = high half
- out_data  out  DW/2  beat payload
- count  out  log2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky: result dropped
- done  out  1  sticky: finished and drained

Behaviour:
- Reset (async): FIFO pointers and count go to 0; FSM goes to IDLE.
  - Output register is cleared: out_valid=0, out_hi=0, out_data=0, out_i=0, out_j=0.
  - full=0, err=0, done=0, finish_seen=0.
  - Reset mid-transfer discards the in-flight beat and all queued entries.
- Push: on a rising edge with wr_en=1, full=0 and finish_seen=0, write {wr_i, wr_j, wr_data} at the write pointer. Write pointer wraps modulo DEPTH.
- Drop cases (result not stored, err set to 1 on that edge):
  - wr_en=1 while full=1, even if a pop happens in the same cycle. full is decoded from the registered count.
  - wr_en=1 while finish_seen=1.
- finish_seen: set on the first edge that samples mm_finish=1; held until reset.
- count: +1 on push, -1 on pop, unchanged on simultaneous push and pop. full = (count==DEPTH).
- FSM states:
  - IDLE: out_valid=0. If count!=0: pop the head into the output register, set out_hi=0, drive out_data=data[DW/2-1:0], go to LO.
  - LO: out_valid=1. On out_valid&&out_ready: out_hi=1, out_data=data[DW-1:DW/2], go to HI.
  - HI: out_valid=1. On handshake:
    - if count!=0: pop the next head, load its low half, out_hi=0, go to LO. No bubble between results.
    - else: go to IDLE.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_i, out_j, out_hi and out_data hold stable.
  - out_valid does not depend combinationally on out_ready.
- Latency: a result pushed at edge N is first presented at edge N+1 (out_valid high in the cycle after N+1) when the FSM is idle.
- Throughput: one result per two cycles when out_ready is held at 1.
- done: set when finish_seen=1, count==0 and state==IDLE; sticky until reset.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'b00, LO=2'b01, HI=2'b10), parameter defaults (IW, DW), and the entry layout {i, j, data}.
- One natural sub-module: mm_result_fifo, a synchronous FIFO with wraparound pointers, count and full/empty.
- The serializer FSM, finish_seen/err/done flags and output register stay in mm_result_drain.

Test Plan:
- Single result: reset, push i=1, j=2, data=40'h12345_6789A, out_ready=1.
  - Expect beat (1,2,hi=0,20'h6789A), then (1,2,hi=1,20'h12345), then out_valid=0.
  - mm_finish pulse afterwards -> done=1 one cycle after the FSM returns to IDLE.
- Backpressure: same push with out_ready=0 for 5 cycles.
  - Low beat held stable all 5 cycles; count=0 after the pop.
  - out_ready=1 -> both beats complete in order.
- Overflow: out_ready=0, push 5 results on consecutive cycles with DEPTH=4.
  - First result goes to the output register; the next 4 fill the FIFO; full=1, count=4.
  - A 6th push -> err=1; that data never appears on the output.
- Wraparound and back-to-back: push 10 results with data=k, out_ready=1.
  - Expect 20 beats in order, with no idle cycle between a HI beat and the next LO beat while results are queued.
- Finish ordering: assert mm_finish while 3 results are queued.
  - done stays 0 until the last HI handshake, then rises.
  - A later wr_en -> err=1, done stays 1.
- Reset mid-operation: assert reset during an HI beat with 2 entries queued.
  - out_valid=0, count=0, err=0, done=0 immediately.
  - After release, a fresh push drains normally.
